// File: rtl/sys_bus_ctrl_pkg.sv
// sys_bus_ctrl_pkg
// Shared definitions for the system bus controller:
//   - state_t   : controller FSM state encoding (IDLE / WAIT / RESP)
//   - SEL_MSB/SEL_LSB : position of the slave-select nibble in the byte address
//   - BASE_*    : slave-select nibble of each standard slave (IMEM, DMEM, GPIO, UART)
package sys_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int SEL_MSB = 31;
  localparam int SEL_LSB = 28;

  localparam logic [3:0] BASE_IMEM = 4'h0;
  localparam logic [3:0] BASE_DMEM = 4'h1;
  localparam logic [3:0] BASE_GPIO = 4'h2;
  localparam logic [3:0] BASE_UART = 4'h3;

endpackage

// File: rtl/sys_bus_ctrl_if.sv
// sys_bus_ctrl_if
// Bundle of the master-side and slave-side bus signals of sys_bus_ctrl.
// Parameters: NUM_SLV (slave ports), DW (data width, multiple of 8).
// Modports:
//   master : the requesting bus master (drives m_req/m_addr/m_wdata/m_wmask/m_wen,
//            receives m_gnt/m_rsp_valid/m_rdata/m_err)
//   slave  : the slave devices (receive s_req/s_addr/s_wdata/s_wmask/s_wen,
//            drive s_rdy/s_rdata; slave i data sits at s_rdata[i*DW +: DW])
//   ctrl   : the controller itself, sitting between the two
interface sys_bus_ctrl_if #(
  parameter int NUM_SLV = 4,
  parameter int DW      = 32
);

  logic                   m_req;
  logic [31:0]            m_addr;
  logic [DW-1:0]          m_wdata;
  logic [DW/8-1:0]        m_wmask;
  logic                   m_wen;
  logic                   m_gnt;
  logic                   m_rsp_valid;
  logic [DW-1:0]          m_rdata;
  logic                   m_err;

  logic [NUM_SLV-1:0]     s_req;
  logic [31:0]            s_addr;
  logic [DW-1:0]          s_wdata;
  logic [DW/8-1:0]        s_wmask;
  logic                   s_wen;
  logic [NUM_SLV-1:0]     s_rdy;
  logic [NUM_SLV*DW-1:0]  s_rdata;

  modport master (
    output m_req, m_addr, m_wdata, m_wmask, m_wen,
    input  m_gnt, m_rsp_valid, m_rdata, m_err
  );

  modport slave (
    input  s_req, s_addr, s_wdata, s_wmask, s_wen,
    output s_rdy, s_rdata
  );

  modport ctrl (
    input  m_req, m_addr, m_wdata, m_wmask, m_wen,
    output m_gnt, m_rsp_valid, m_rdata, m_err,
    output s_req, s_addr, s_wdata, s_wmask, s_wen,
    input  s_rdy, s_rdata
  );

endinterface

// File: rtl/sys_bus_tmo.sv
// sys_bus_tmo
// Slave stall counter for sys_bus_ctrl, only instantiated when
// SYS_BUS_TIMEOUT_EN is defined.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clr      : clears the counter (asserted on the cycle a transfer is accepted)
//   en       : counts while the controller waits on a slave
//   expired  : high in the WAIT cycle where the count reached TIMEOUT-1
module sys_bus_tmo #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  // Clearing on accept means the first WAIT cycle always sees a count of 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/sys_bus_ctrl.sv
// sys_bus_ctrl
// Single-master system bus controller. Accepts one transfer at a time in IDLE,
// decodes the slave from address bits [31:28], holds a one-hot request to that
// slave until it strobes ready, then returns a one-cycle response to the master.
// Unmapped slaves get an immediate error response.
// Parameters: NUM_SLV (1..16), DW (multiple of 8), TIMEOUT (2..255).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : sys_bus_ctrl_if.ctrl (master request/response and slave lanes)
// Configuration macro: SYS_BUS_TIMEOUT_EN -- when defined, a stalled slave is
// abandoned with an error after TIMEOUT WAIT cycles; otherwise WAIT never ends
// without the slave's ready strobe.
module sys_bus_ctrl
  import sys_bus_ctrl_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input logic        clk,
  input logic        rst,
  sys_bus_ctrl_if.ctrl bus
);

  if (NUM_SLV < 1 || NUM_SLV > 16) begin : g_bad_num_slv
    $error("sys_bus_ctrl: NUM_SLV must be within 1..16");
  end
  if (DW < 8 || (DW % 8) != 0) begin : g_bad_dw
    $error("sys_bus_ctrl: DW must be a positive multiple of 8");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("sys_bus_ctrl: TIMEOUT must be within 2..255");
  end

  localparam logic [4:0] NUM_SLV_W = 5'(NUM_SLV);

  state_t             state;
  state_t             next_state;
  logic [3:0]         m_idx;
  logic [3:0]         idx_q;
  logic               mapped;
  logic               accept;
  logic               in_wait;
  logic               sel_rdy;
  logic               tmo_hit;
  logic [NUM_SLV-1:0] sel_oh;
  logic [DW-1:0]      sel_data;
  logic [DW-1:0]      rdata_q;
  logic               err_q;
  logic [31:0]        addr_q;
  logic [DW-1:0]      wdata_q;
  logic [DW/8-1:0]    wmask_q;
  logic               wen_q;

  assign m_idx   = bus.m_addr[SEL_MSB:SEL_LSB];
  assign mapped  = ({1'b0, m_idx} < NUM_SLV_W);
  assign accept  = (state == IDLE) && bus.m_req;
  assign in_wait = (state == WAIT);

  // Slave select decode from the latched index; only the selected slave's
  // ready and read data are ever looked at.
  always_comb begin
    sel_oh   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == 4'(i)) begin
        sel_oh[i] = 1'b1;
        sel_data  = bus.s_rdata[i*DW +: DW];
      end
    end
  end

  assign sel_rdy = |(bus.s_rdy & sel_oh);

`ifdef SYS_BUS_TIMEOUT_EN
  sys_bus_tmo #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (in_wait),
    .expired (tmo_hit)
  );
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Unmapped accesses skip WAIT entirely. In WAIT a ready strobe has priority
  // over timeout expiry, so a slave answering in the terminal cycle still wins.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (bus.m_req) begin
          next_state = mapped ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (sel_rdy || tmo_hit) begin
          next_state = RESP;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request fields are latched on accept; the response data and error flag
  // are settled by the time the FSM reaches RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      wen_q   <= 1'b0;
    end else begin
      if (accept) begin
        idx_q   <= m_idx;
        addr_q  <= bus.m_addr;
        wdata_q <= bus.m_wdata;
        wmask_q <= bus.m_wmask;
        wen_q   <= bus.m_wen;
        err_q   <= !mapped;
        if (!mapped) begin
          rdata_q <= '0;
        end
      end
      if (in_wait) begin
        if (sel_rdy) begin
          rdata_q <= sel_data;
          err_q   <= 1'b0;
        end else if (tmo_hit) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  // Grant is masked during reset so nothing looks accepted while the
  // controller is being cleared.
  always_comb begin
    bus.m_gnt       = (state == IDLE) && bus.m_req && !rst;
    bus.m_rsp_valid = (state == RESP);
    bus.m_err       = (state == RESP) && err_q;
    bus.s_req       = in_wait ? sel_oh : '0;
  end

  assign bus.m_rdata = rdata_q;
  assign bus.s_addr  = addr_q;
  assign bus.s_wdata = wdata_q;
  assign bus.s_wmask = wmask_q;
  assign bus.s_wen   = wen_q;

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// tb_sys_bus_ctrl
// Self-checking bench for sys_bus_ctrl (NUM_SLV=4, DW=32, TIMEOUT=16).
// A cycle-indexed expectation table is filled from the transfer rules
// (grant cycle, request window, response cycle, data/error) and compared
// against the DUT on every falling edge; a few literal checks pin the model.
// Honours SYS_BUS_TIMEOUT_EN for the stall-timeout scenarios.
module tb_sys_bus_ctrl;
  import sys_bus_ctrl_pkg::*;

  localparam int NUM_SLV = 4;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;
  localparam int NCYC    = 1024;
`ifdef SYS_BUS_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  sys_bus_ctrl_if #(.NUM_SLV(NUM_SLV), .DW(DW)) bus ();

  sys_bus_ctrl #(
    .NUM_SLV (NUM_SLV),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  logic               exp_gnt   [NCYC];
  logic [NUM_SLV-1:0] exp_sreq  [NCYC];
  logic               exp_rsp   [NCYC];
  logic               exp_err   [NCYC];
  logic [DW-1:0]      exp_rdata [NCYC];

  logic [31:0]   cur_addr;
  logic [DW-1:0] cur_wdata;
  logic [3:0]    cur_wmask;
  logic          cur_wen;

  int            gnt_log[$];
  int            rsp_cyc_log[$];
  logic [DW-1:0] rsp_data_log[$];
  logic          rsp_err_log[$];
  int            sreq3_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the expectation table, plus event logs.
  always @(negedge clk) begin
    if (chk_en && cyc < NCYC) begin
      checkOutput("m_gnt", 64'(bus.m_gnt), 64'(exp_gnt[cyc]));
      checkOutput("s_req", 64'(bus.s_req), 64'(exp_sreq[cyc]));
      checkOutput("m_rsp_valid", 64'(bus.m_rsp_valid), 64'(exp_rsp[cyc]));
      checkOutput("m_err", 64'(bus.m_err), 64'(exp_rsp[cyc] ? exp_err[cyc] : 1'b0));
      if (exp_rsp[cyc]) begin
        checkOutput("m_rdata", 64'(bus.m_rdata), 64'(exp_rdata[cyc]));
      end
      if (exp_sreq[cyc] != '0) begin
        checkOutput("s_addr", 64'(bus.s_addr), 64'(cur_addr));
        checkOutput("s_wdata", 64'(bus.s_wdata), 64'(cur_wdata));
        checkOutput("s_wmask", 64'(bus.s_wmask), 64'(cur_wmask));
        checkOutput("s_wen", 64'(bus.s_wen), 64'(cur_wen));
      end
    end
    if (bus.m_gnt) gnt_log.push_back(cyc);
    if (bus.m_rsp_valid) begin
      rsp_cyc_log.push_back(cyc);
      rsp_data_log.push_back(bus.m_rdata);
      rsp_err_log.push_back(bus.m_err);
    end
    if (bus.s_req[3]) sreq3_cnt++;
  end

  task automatic setMaster(input logic [31:0] addr, input logic [DW-1:0] wdata,
                           input logic [3:0] wmask, input logic wen);
    bus.m_req   = 1'b1;
    bus.m_addr  = addr;
    bus.m_wdata = wdata;
    bus.m_wmask = wmask;
    bus.m_wen   = wen;
    cur_addr    = addr;
    cur_wdata   = wdata;
    cur_wmask   = wmask;
    cur_wen     = wen;
    for (int i = 0; i < NUM_SLV; i++) begin
      bus.s_rdata[i*DW +: DW] = 32'hDEAD_0000 | 32'(i);
    end
  endtask

  // One transfer starting in an IDLE cycle; the slave strobes ready after
  // 'delay' stall cycles. Returns in the next IDLE cycle.
  task automatic applyStimulus(input logic [31:0] addr, input logic [DW-1:0] wdata,
                               input logic [3:0] wmask, input logic wen,
                               input int delay, input logic [DW-1:0] rdata);
    int                 t;
    int                 waits;
    logic [3:0]         idx;
    logic [NUM_SLV-1:0] oh;
    logic               err;
    t   = cyc;
    idx = addr[31:28];
    setMaster(addr, wdata, wmask, wen);
    exp_gnt[t] = 1'b1;
    if (int'(idx) >= NUM_SLV) begin
      exp_rsp[t+1]   = 1'b1;
      exp_err[t+1]   = 1'b1;
      exp_rdata[t+1] = '0;
      @(posedge clk); #1;
      bus.m_req = 1'b0;
      @(posedge clk); #1;
    end else begin
      bus.s_rdata[int'(idx)*DW +: DW] = rdata;
      oh = NUM_SLV'(1) << idx;
      if (TMO_ON && delay >= TIMEOUT) begin
        waits = TIMEOUT;
        err   = 1'b1;
      end else begin
        waits = delay + 1;
        err   = 1'b0;
      end
      for (int k = 1; k <= waits; k++) exp_sreq[t+k] = oh;
      exp_rsp[t+waits+1]   = 1'b1;
      exp_err[t+waits+1]   = err;
      exp_rdata[t+waits+1] = err ? '0 : rdata;
      @(posedge clk); #1;
      bus.m_req = 1'b0;
      for (int k = 0; k < waits; k++) begin
        bus.s_rdy = (k == delay) ? oh : (((k % 2) == 1) ? ~oh : '0);
        @(posedge clk); #1;
      end
      bus.s_rdy = '0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    int n_rsp;
    logic [DW-1:0] d[3];
    for (int i = 0; i < NCYC; i++) begin
      exp_gnt[i]   = 1'b0;
      exp_sreq[i]  = '0;
      exp_rsp[i]   = 1'b0;
      exp_err[i]   = 1'b0;
      exp_rdata[i] = '0;
    end
    bus.m_req   = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_wmask = '0;
    bus.m_wen   = 1'b0;
    bus.s_rdy   = '0;
    bus.s_rdata = '0;
    cur_addr = '0; cur_wdata = '0; cur_wmask = '0; cur_wen = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_m_rdata", 64'(bus.m_rdata), 64'h0);
    checkOutput("rst_s_addr", 64'(bus.s_addr), 64'h0);
    checkOutput("rst_s_wen", 64'(bus.s_wen), 64'h0);
    checkOutput("rst_s_req", 64'(bus.s_req), 64'h0);
    checkOutput("rst_m_rsp_valid", 64'(bus.m_rsp_valid), 64'h0);
    chk_en = 1'b1;
    @(posedge clk); #1;

    $display("[TB] zero-wait DMEM read");
    applyStimulus({BASE_DMEM, 28'h000_0004}, '0, 4'h0, 1'b0, 0, 32'hCAFE_F00D);
    checkOutput("rd_latency", 64'(rsp_cyc_log[$] - gnt_log[$]), 64'd2);
    checkOutput("rd_data", 64'(rsp_data_log[$]), 64'hCAFE_F00D);
    checkOutput("rd_err", 64'(rsp_err_log[$]), 64'h0);

    $display("[TB] GPIO byte write with stalls");
    n_rsp = rsp_cyc_log.size();
    applyStimulus(32'h2000_0000, 32'h0000_00A5, 4'b0001, 1'b1, 3, 32'h0BAD_0002);
    checkOutput("wr_s_wen", 64'(bus.s_wen), 64'h1);
    checkOutput("wr_s_wdata", 64'(bus.s_wdata), 64'hA5);
    checkOutput("wr_s_wmask", 64'(bus.s_wmask), 64'h1);
    checkOutput("wr_rsp_count", 64'(rsp_cyc_log.size() - n_rsp), 64'd1);
    checkOutput("wr_err", 64'(rsp_err_log[$]), 64'h0);

    $display("[TB] unmapped access");
    applyStimulus(32'h7000_0000, '0, 4'h0, 1'b0, 0, '0);
    checkOutput("unm_latency", 64'(rsp_cyc_log[$] - gnt_log[$]), 64'd1);
    checkOutput("unm_err", 64'(rsp_err_log[$]), 64'h1);
    checkOutput("unm_rdata", 64'(rsp_data_log[$]), 64'h0);

    $display("[TB] directed vectors");
    applyStimulus({BASE_IMEM, 28'h000_0010}, '0, 4'h0, 1'b0, 0, 32'h1234_5678);
    applyStimulus({BASE_UART, 28'h000_0004}, 32'hDEAD_BEEF, 4'hF, 1'b1, 1, 32'h0000_0033);
    applyStimulus({BASE_GPIO, 28'h000_0100}, '0, 4'h0, 1'b0, 5, 32'hA5A5_5A5A);
    applyStimulus(32'h4000_0000, '0, 4'h0, 1'b0, 0, '0);
    applyStimulus(32'hF000_0000, 32'h1111_1111, 4'hC, 1'b1, 0, '0);
    applyStimulus(32'h1FFF_FFFC, '0, 4'h0, 1'b0, 2, 32'h8000_0001);
    applyStimulus({BASE_UART, 28'h0}, '0, 4'h0, 1'b0, 0, 32'h0000_0000);

`ifdef SYS_BUS_TIMEOUT_EN
    $display("[TB] UART stall timeout");
    sreq3_cnt = 0;
    applyStimulus({BASE_UART, 28'h0}, '0, 4'h0, 1'b0, 100, 32'h5A5A_0000);
    checkOutput("tmo_sreq_cycles", 64'(sreq3_cnt), 64'd16);
    checkOutput("tmo_err", 64'(rsp_err_log[$]), 64'h1);
    sreq3_cnt = 0;
    applyStimulus({BASE_UART, 28'h0}, '0, 4'h0, 1'b0, 15, 32'h5A5A_0001);
    checkOutput("tmo_last_sreq_cycles", 64'(sreq3_cnt), 64'd16);
    checkOutput("tmo_last_err", 64'(rsp_err_log[$]), 64'h0);
    checkOutput("tmo_last_data", 64'(rsp_data_log[$]), 64'h5A5A_0001);
`else
    $display("[TB] long stall without timeout");
    applyStimulus({BASE_DMEM, 28'h0}, '0, 4'h0, 1'b0, 40, 32'h0F0F_F0F0);
    checkOutput("stall_latency", 64'(rsp_cyc_log[$] - gnt_log[$]), 64'd42);
    checkOutput("stall_err", 64'(rsp_err_log[$]), 64'h0);
`endif

    $display("[TB] reset during WAIT");
    t = cyc;
    n_rsp = rsp_cyc_log.size();
    setMaster({BASE_DMEM, 28'h000_0008}, 32'h5555_AAAA, 4'hF, 1'b1);
    exp_gnt[t]    = 1'b1;
    exp_sreq[t+1] = 4'b0010;
    exp_sreq[t+2] = 4'b0010;
    @(posedge clk); #1;
    bus.m_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_s_req", 64'(bus.s_req), 64'h0);
    checkOutput("abort_m_gnt", 64'(bus.m_gnt), 64'h0);
    checkOutput("abort_m_rsp_valid", 64'(bus.m_rsp_valid), 64'h0);
    checkOutput("abort_m_err", 64'(bus.m_err), 64'h0);
    checkOutput("abort_m_rdata", 64'(bus.m_rdata), 64'h0);
    checkOutput("abort_s_addr", 64'(bus.s_addr), 64'h0);
    checkOutput("abort_s_wdata", 64'(bus.s_wdata), 64'h0);
    checkOutput("abort_s_wmask", 64'(bus.s_wmask), 64'h0);
    checkOutput("abort_s_wen", 64'(bus.s_wen), 64'h0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("abort_no_rsp", 64'(rsp_cyc_log.size() - n_rsp), 64'd0);

    $display("[TB] back-to-back DMEM reads with m_req held");
    d[0] = 32'h1111_0001;
    d[1] = 32'h2222_0002;
    d[2] = 32'h3333_0003;
    t = cyc;
    setMaster({BASE_DMEM, 28'h000_0004}, '0, 4'h0, 1'b0);
    bus.s_rdy = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      exp_gnt[t+3*k]     = 1'b1;
      exp_sreq[t+3*k+1]  = 4'b0010;
      exp_rsp[t+3*k+2]   = 1'b1;
      exp_err[t+3*k+2]   = 1'b0;
      exp_rdata[t+3*k+2] = d[k];
    end
    for (int k = 0; k < 3; k++) begin
      bus.s_rdata[1*DW +: DW] = d[k];
      @(posedge clk); #1;
      if (k == 2) bus.m_req = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    bus.s_rdy = '0;
    checkOutput("b2b_gnt_gap1", 64'(gnt_log[$-1] - gnt_log[$-2]), 64'd3);
    checkOutput("b2b_gnt_gap2", 64'(gnt_log[$] - gnt_log[$-1]), 64'd3);
    checkOutput("b2b_data0", 64'(rsp_data_log[$-2]), 64'h1111_0001);
    checkOutput("b2b_data1", 64'(rsp_data_log[$-1]), 64'h2222_0002);
    checkOutput("b2b_data2", 64'(rsp_data_log[$]), 64'h3333_0003);

    repeat (4) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sys_bus_ctrl.md
SYS_BUS_CTRL -- requirements
Module: sys_bus_ctrl

Interface
REQ-001 SHALL have parameter NUM_SLV, default 4: number of slave ports, legal range 1..16.
REQ-002 SHALL have parameter DW, default 32: data width, a multiple of 8.
REQ-003 SHALL have parameter TIMEOUT, default 16: the maximum number of cycles a slave may stall before an error response, legal range 2..255.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port m_req, input, 1 bit: the master requests a transfer.
REQ-007 SHALL have port m_addr, input, 32 bits: the byte address; bits [31:28] select the slave.
REQ-008 SHALL have ports m_wdata (input, DW bits), m_wmask (input, DW/8 bits) and m_wen (input, 1 bit): write data, byte mask and write enable.
REQ-009 SHALL have port m_gnt, output, 1 bit: a one-cycle pulse when the request is accepted.
REQ-010 SHALL have ports m_rsp_valid (output, 1 bit), m_rdata (output, DW bits) and m_err (output, 1 bit): the response strobe, read data and error flag.
REQ-011 SHALL have port s_req, output, NUM_SLV bits: one-hot request to the selected slave.
REQ-012 SHALL have ports s_addr (output, 32 bits), s_wdata (output, DW bits), s_wmask (output, DW/8 bits) and s_wen (output, 1 bit): latched request fields, broadcast to all slaves.
REQ-013 SHALL have port s_rdy, input, NUM_SLV bits: each slave's completion strobe.
REQ-014 SHALL have port s_rdata, input, NUM_SLV*DW bits: slave i's read data occupies bits [i*DW +: DW].

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-016 In IDLE with m_req=1, SHALL assert m_gnt for one cycle, latch addr/wdata/wmask/wen into the s_* registers, and compute idx=m_addr[31:28].
REQ-017 If idx < NUM_SLV, SHALL go to WAIT; otherwise (unmapped) SHALL go directly to RESP with error set and no s_req asserted.
REQ-018 In WAIT, SHALL hold s_req[idx]=1 and all other s_req bits 0; on s_rdy[idx]=1, SHALL register s_rdata[idx] into m_rdata, drop s_req the next cycle and go to RESP.
REQ-019 In WAIT, SHALL ignore s_rdy bits other than idx.
REQ-020 In RESP, SHALL assert m_rsp_valid for exactly one cycle, then return to IDLE.
REQ-021 A new m_req SHALL be accepted in IDLE only, so back-to-back transfers take at least 3 cycles each.
REQ-022 Latency with a zero-wait slave (s_rdy=1 in the first WAIT cycle): m_rsp_valid SHALL be 2 cycles after the m_gnt cycle.
REQ-023 m_err SHALL be valid only while m_rsp_valid=1, and SHALL be 0 otherwise.
REQ-024 For an error response, m_rdata SHALL be 0.
REQ-025 For a write response, m_rdata SHALL be the captured s_rdata (don't-care for the master), with m_rsp_valid still asserted.
REQ-026 m_req held high across RESP SHALL be accepted as a new transfer in the following IDLE cycle.

Reset
REQ-027 With rst=1 at a clock edge, SHALL enter IDLE.
REQ-028 Reset SHALL clear m_gnt, m_rsp_valid, m_err, m_rdata, s_req, s_addr, s_wdata, s_wmask and s_wen to 0.
REQ-029 Reset mid-WAIT SHALL drop s_req in the next cycle and SHALL produce no response for the aborted transfer.

Configuration
REQ-030 With macro SYS_BUS_TIMEOUT_EN defined, SHALL run an 8-bit stall counter that clears on entry to WAIT and increments each WAIT cycle.
REQ-031 With SYS_BUS_TIMEOUT_EN defined, the WAIT cycle in which the counter equals TIMEOUT-1 without s_rdy[idx] SHALL go to RESP with m_err=1, and s_req SHALL drop.
REQ-032 With SYS_BUS_TIMEOUT_EN defined, s_rdy arriving in that same terminal cycle SHALL win: normal response, m_err=0.
REQ-033 Without SYS_BUS_TIMEOUT_EN, no counter SHALL be built, and WAIT SHALL wait indefinitely.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the slave-select field position ([31:28]), and the base-nibble constants (IMEM 0, DMEM 1, GPIO 2, UART 3).
REQ-035 The sub-module sys_bus_tmo SHALL contain the timeout counter, instantiated only under SYS_BUS_TIMEOUT_EN.

Verification
REQ-036 Read 0x1000_0004 with DMEM s_rdy=1 immediately and s_rdata[1]=0xCAFE_F00D -> m_gnt at T, s_req=4'b0010 at T+1, m_rsp_valid at T+2, m_rdata=0xCAFE_F00D, m_err=0.
REQ-037 Write 0x2000_0000 with data 0x0000_00A5 and mask 4'b0001 -> s_wen=1, s_wdata=0xA5, s_wmask=0001, s_req=0100 until s_rdy[2], then one m_rsp_valid pulse, m_err=0.
REQ-038 Access 0x7000_0000 with NUM_SLV=4 -> s_req stays 0, m_rsp_valid at T+1, m_err=1, m_rdata=0.
REQ-039 With SYS_BUS_TIMEOUT_EN and TIMEOUT=16, UART never ready -> s_req[3] high for 16 cycles, then m_rsp_valid with m_err=1; repeat with s_rdy in the 16th cycle -> m_err=0.
REQ-040 rst=1 in the 2nd WAIT cycle -> all outputs 0 next cycle, and no m_rsp_valid pulse ever appears for that transfer.
REQ-041 m_req held high for 3 consecutive DMEM reads -> m_gnt every 3 cycles, with responses in order.
